// File: rtl/clocked_rr_arbiter_16.sv
// clocked_rr_arbiter_16: 16-way registered arbiter with hold timeout.
// Ports: clk, reset (async, active-high), req[15:0], release_i
//   (owner done, GRANT only), grant_valid, grant_idx[3:0],
//   grant_onehot[15:0], grant_expired (timeout pulse).
// Config: define RR_FAIRNESS_EN for rotating priority; otherwise
//   strict priority with D15 highest. MAX_HOLD legal 1..15.
// Note: the owner-done input is named release_i because "release"
//   is a reserved word in SystemVerilog.
module clocked_rr_arbiter_16 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] req,
  input  logic        release_i,
  output logic        grant_valid,
  output logic [3:0]  grant_idx,
  output logic [15:0] grant_onehot,
  output logic        grant_expired
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_t      state_q, state_d;
  logic        valid_q, valid_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] onehot_q, onehot_d;
  logic        exp_q, exp_d;
  logic [3:0]  hold_q, hold_d;
  logic [3:0]  ptr;

`ifdef RR_FAIRNESS_EN
  logic [3:0]  ptr_q, ptr_d;
  assign ptr = ptr_q;
`else
  assign ptr = 4'd15;
`endif

  // Downward search from ptr, wrapping 0 -> 15.
  logic       win_found;
  logic [3:0] win_idx;
  logic [3:0] cand;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < 16; k++) begin
      cand = ptr - 4'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  logic owner_req;
  logic timeout;
  logic grant_end;

  assign owner_req = req[idx_q];
  assign timeout   = (hold_q == HOLD_LAST);
  assign grant_end = release_i | ~owner_req | timeout;

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    idx_d    = idx_q;
    onehot_d = onehot_q;
    exp_d    = 1'b0;
    hold_d   = hold_q;
`ifdef RR_FAIRNESS_EN
    ptr_d    = ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        valid_d  = 1'b0;
        idx_d    = '0;
        onehot_d = '0;
        if (win_found) begin
          state_d  = GRANT;
          valid_d  = 1'b1;
          idx_d    = win_idx;
          onehot_d = 16'd1 << win_idx;
          hold_d   = '0;
        end
      end
      GRANT: begin
        if (grant_end) begin
          state_d  = IDLE;
          valid_d  = 1'b0;
          idx_d    = '0;
          onehot_d = '0;
          // Pulse only for a pure timeout end.
          exp_d    = timeout & ~release_i & owner_req;
`ifdef RR_FAIRNESS_EN
          ptr_d    = idx_q - 4'd1;
`endif
        end else if (hold_q != 4'hF) begin
          hold_d = hold_q + 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      idx_q    <= '0;
      onehot_q <= '0;
      exp_q    <= 1'b0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
      exp_q    <= exp_d;
      hold_q   <= hold_d;
    end
  end

`ifdef RR_FAIRNESS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ptr_q <= 4'd15;
    else       ptr_q <= ptr_d;
  end
`endif

  assign grant_valid   = valid_q;
  assign grant_idx     = idx_q;
  assign grant_onehot  = onehot_q;
  assign grant_expired = exp_q;

endmodule
